// File: rtl/exposure_timer.sv
// exposure_timer: prescaled exposure countdown with single-shot and
// continuous modes. Abort beats expiry, and expiry beats start. All outputs
// come straight from registers.
module exposure_timer #(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   exp_time,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  output logic               busy,
  output logic               ovf,
  output logic [CNT_W-1:0]   remaining
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_remaining, w_remaining_nxt;
  logic [PRESC_W-1:0] r_presc_cnt, w_presc_cnt_nxt;
  logic [PRESC_W-1:0] r_presc,     w_presc_nxt;
  logic               r_mode,      w_mode_nxt;
  logic               r_ovf,       w_ovf_nxt;
  logic               w_tick;
  logic               w_last;

  // A tick fires on the cycle the prescaler reaches the latched setting.
  assign w_tick = (r_presc_cnt == r_presc);
  // Expiry happens when the final tick of the exposure arrives.
  assign w_last = (r_remaining == CNT_W'(1));

  // Compute next state and next register values. Every value starts as a
  // hold, except ovf, which is a single-cycle pulse.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_presc_cnt_nxt = r_presc_cnt;
    w_presc_nxt     = r_presc;
    w_mode_nxt      = r_mode;
    w_ovf_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if (exp_time != '0) begin
            w_state_nxt     = S_RUN;
            w_remaining_nxt = exp_time;
            w_mode_nxt      = mode;
            w_presc_nxt     = prescale;
            w_presc_cnt_nxt = '0;
          end else begin
            // A zero-length exposure expires at once and never goes busy.
            w_ovf_nxt       = 1'b1;
            w_remaining_nxt = '0;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          // Abort wins even on an expiry cycle, so ovf stays low here.
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
          w_presc_cnt_nxt = '0;
        end else if (w_tick) begin
          w_presc_cnt_nxt = '0;
          if (w_last) begin
            w_ovf_nxt = 1'b1;
            if (r_mode && exp_time != '0) begin
              w_remaining_nxt = exp_time;
            end else begin
              w_state_nxt     = S_IDLE;
              w_remaining_nxt = '0;
            end
          end else begin
            w_remaining_nxt = r_remaining - CNT_W'(1);
          end
        end else begin
          w_presc_cnt_nxt = r_presc_cnt + PRESC_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register the state with a synchronous active-low reset. Reset overrides
  // every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_presc_cnt <= '0;
      r_presc     <= '0;
      r_mode      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_presc_cnt <= w_presc_cnt_nxt;
      r_presc     <= w_presc_nxt;
      r_mode      <= w_mode_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign busy      = (r_state == S_RUN);
  assign ovf       = r_ovf;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_exposure_timer.sv
// Bench for exposure_timer. Stimulus drives the inputs and pushes the
// expected outputs into a queue. The expected values come from an
// elapsed-cycle model of the exposure. A monitor on the falling edge pops
// each expectation and compares it against the DUT outputs.
module tb_exposure_timer;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;

  logic               clk;
  logic               reset;
  logic [CNT_W-1:0]   exp_time;
  logic [PRESC_W-1:0] prescale;
  logic               start, abort, mode;
  logic               busy, ovf;
  logic [CNT_W-1:0]   remaining;

  exposure_timer #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .reset(reset), .exp_time(exp_time), .prescale(prescale),
    .start(start), .abort(abort), .mode(mode),
    .busy(busy), .ovf(ovf), .remaining(remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    int             cyc;
    logic           busy;
    logic           ovf;
    logic [CNT_W-1:0] rem;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // The model keeps only the elapsed cycles in the current period and the
  // exposure parameters that were latched at start.
  bit m_act  = 0;
  bit m_mode = 0;
  int m_k    = 0;
  int m_E    = 0;
  int m_P    = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare an expectation once the edge it describes has passed.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (e.cyc != cyc_cnt || busy !== e.busy || ovf !== e.ovf || remaining !== e.rem) begin
        n_fail++;
        $display("FAIL outputs cyc%0d: got busy=%0b ovf=%0b rem=%0d, want busy=%0b ovf=%0b rem=%0d (tag %0d)",
                 cyc_cnt, busy, ovf, remaining, e.busy, e.ovf, e.rem, e.cyc);
      end
    end
  end

  // Model the edge that consumes the inputs currently applied.
  task automatic model_step();
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.busy = 1'b0;
    e.ovf  = 1'b0;
    e.rem  = '0;
    if (!reset) begin
      m_act = 0;
    end else if (m_act) begin
      if (abort) begin
        m_act = 0;
      end else begin
        m_k++;
        if (m_k == m_E * (m_P + 1)) begin
          e.ovf = 1'b1;
          if (m_mode && exp_time != 0) begin
            m_E = exp_time;
            m_k = 0;
          end else begin
            m_act = 0;
          end
        end
      end
    end else if (start && !abort) begin
      if (exp_time != 0) begin
        m_act  = 1;
        m_E    = exp_time;
        m_P    = prescale;
        m_mode = mode;
        m_k    = 0;
      end else begin
        e.ovf = 1'b1;
      end
    end
    if (m_act) begin
      e.busy = 1'b1;
      e.rem  = CNT_W'(m_E - m_k / (m_P + 1));
    end
    q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit st, input bit ab, input bit md,
                       input int et, input int ps);
    @(posedge clk);
    #1;
    reset    = rst;
    start    = st;
    abort    = ab;
    mode     = md;
    exp_time = CNT_W'(et);
    prescale = PRESC_W'(ps);
    model_step();
  endtask

  // Hold inputs quiet (start low) for n cycles, keeping exp_time and prescale.
  task automatic idle(input int n, input int et, input int ps, input bit md);
    for (int i = 0; i < n; i++) drive(1, 0, 0, md, et, ps);
  endtask

  initial begin
    reset = 0; start = 0; abort = 0; mode = 0; exp_time = '0; prescale = '0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 5, 0);
    // Single shot, E=3, P=0.
    drive(1, 1, 0, 0, 3, 0);
    idle(5, 3, 0, 0);
    // Prescaled run, E=2, P=3.
    drive(1, 1, 0, 0, 2, 3);
    idle(10, 2, 3, 0);
    // Continuous run, E=4, P=1, then exp_time drops to 2 mid-run.
    drive(1, 1, 0, 1, 4, 1);
    idle(19, 4, 1, 1);
    idle(12, 2, 1, 1);
    drive(1, 0, 1, 1, 2, 1);
    idle(2, 2, 1, 0);
    // Abort at cycle 5 of a 10-tick run.
    drive(1, 1, 0, 0, 10, 0);
    idle(4, 10, 0, 0);
    drive(1, 0, 1, 0, 10, 0);
    idle(2, 10, 0, 0);
    // Abort arrives on the expiry edge.
    drive(1, 1, 0, 0, 3, 0);
    idle(2, 3, 0, 0);
    drive(1, 0, 1, 0, 3, 0);
    idle(2, 3, 0, 0);
    // Start in IDLE together with abort is suppressed.
    drive(1, 1, 1, 0, 3, 0);
    idle(2, 3, 0, 0);
    // Zero exposure, then a continuous run whose reload value is zero.
    drive(1, 1, 0, 0, 0, 0);
    idle(2, 0, 0, 0);
    drive(1, 1, 0, 1, 2, 0);
    idle(3, 2, 0, 1);
    idle(3, 0, 0, 1);
    // Continuous with E*(P+1)=1 pulses ovf on every cycle.
    drive(1, 1, 0, 1, 1, 0);
    idle(4, 1, 0, 1);
    drive(1, 0, 1, 1, 1, 0);
    // Maximum prescale over a short count.
    drive(1, 1, 0, 0, 2, 15);
    idle(34, 2, 15, 0);
    // Reset mid-run with start held through the reset release.
    drive(1, 1, 0, 0, 20, 0);
    idle(6, 20, 0, 0);
    drive(0, 1, 0, 0, 20, 0);
    drive(1, 1, 0, 0, 20, 0);
    idle(3, 20, 0, 0);
    drive(1, 0, 1, 0, 20, 0);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15))
                                        : int'($urandom_range(0, 2)));
    end
    // Drain: give the monitor a bounded number of cycles to empty the queue.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
